// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Brief   : Shared constants and types for the VGA scanout slice: 640x480
//           frame geometry, sync window bounds, framebuffer size, scan FSM
//           states and the control word carried down the pixel pipeline.
// Rev     : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int FB_WORDS     = 76800;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN      = 2'd1,
    STOP_PEND = 2'd2
  } scan_state_t;

  // Per-pixel control travelling alongside the memory fetch.
  typedef struct packed {
    logic       act;   // active (visible) pixel
    logic       hs;    // horizontal sync, active-low
    logic       vs;    // vertical sync, active-low
    logic       last;  // final visible pixel of the frame
    logic [1:0] bsel;  // byte lane within the 32-bit word
  } pix_ctl_t;

  localparam pix_ctl_t PIX_CTL_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1,
                                        last: 1'b0, bsel: 2'd0};

  // Colour bar k -> {R,G,B}; each channel fully on or off.
  function automatic logic [23:0] bar_rgb(input logic [2:0] k);
    bar_rgb = {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Horizontal/vertical raster counters and the stage-0 decodes
//           (active area, syncs, last visible pixel, frame wrap). Counters
//           are held at the origin while run_i is low.
// Rev     : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOT),
  localparam int VW      = $clog2(V_TOT)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic act_o,
  output logic hs_o,
  output logic vs_o,
  output logic last_o,
  output logic wrap_o
);

  localparam int HSS = H_ACTIVE + H_FP;
  localparam int HSE = H_ACTIVE + H_FP + H_SYNC;
  localparam int VSS = V_ACTIVE + V_FP;
  localparam int VSE = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_end, v_end;

  assign h_end  = (hcnt_q == HW'(H_TOT - 1));
  assign v_end  = (vcnt_q == VW'(V_TOT - 1));
  assign wrap_o = run_i && h_end && v_end;

  assign act_o  = run_i && (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
  assign hs_o   = !((hcnt_q >= HW'(HSS)) && (hcnt_q < HW'(HSE)));
  assign vs_o   = !((vcnt_q >= VW'(VSS)) && (vcnt_q < VW'(VSE)));
  assign last_o = act_o && (hcnt_q == HW'(H_ACTIVE - 1)) && (vcnt_q == VW'(V_ACTIVE - 1));

  // Next raster position: hold at origin when stopped, else step and wrap.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!run_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_end) begin
      hcnt_d = '0;
      vcnt_d = v_end ? '0 : vcnt_q + VW'(1);
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module  : vga_scanout
// Brief   : Scans a 4-pixels-per-word grayscale framebuffer through a
//           1-cycle-latency read port and drives VGA sync + RGB with a
//           3-stage pipeline (counters -> fetch -> byte select -> pins).
//           Optional feature macro: VGA_TEST_PATTERN_EN adds a test_mode
//           input that replaces framebuffer pixels with 8 colour bars.
// Rev     : 1.0 - initial release
// ============================================================================
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 17
) (
  input  logic              clkVga,
  input  logic              reset,
  input  logic              enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       VGAData,
  output logic              H_SyncOut,
  output logic              V_SyncOut,
  output logic [7:0]        RedOut,
  output logic [7:0]        GreenOut,
  output logic [7:0]        BlueOut,
  output logic              visible,
  output logic              vga_sync,
  output logic              frame_done,
  output logic              busy
);

  // Pixel index needs two extra bits for the byte lane below the word address.
  localparam int PW = ADDR_W + 2;

  scan_state_t     state_q;
  logic            busy_q;
  logic            running;
  logic            act0, hs0, vs0, last0, wrap;
  logic            tm0;
  logic [PW-1:0]   p_q, p_d;
  pix_ctl_t        ctl1_q, ctl2_q;
  logic            mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]      pix_byte;
  logic [23:0]     rgb_d, rgb_q;
  logic            vis_q, hs3_q, vs3_q, last3_q, fdone_q;

  assign running = (state_q != IDLE);

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk_i  (clkVga),
    .rst_ni (reset),
    .run_i  (running),
    .act_o  (act0),
    .hs_o   (hs0),
    .vs_o   (vs0),
    .last_o (last0),
    .wrap_o (wrap)
  );

  // Scan FSM; stop requests only take effect at the frame wrap.
  always_ff @(posedge clkVga or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (!enable) begin
            if (wrap) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= STOP_PEND;
            end
          end
        end
        STOP_PEND: begin
          if (wrap) begin
            if (enable) begin
              state_q <= SCAN;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel index advances once per active pixel and returns to 0 after the
  // last visible pixel, at the frame wrap and while idle.
  always_comb begin
    p_d = p_q;
    if (!running || wrap) begin
      p_d = '0;
    end else if (act0) begin
      p_d = last0 ? '0 : p_q + PW'(1);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BPW   = $clog2(BAR_W + 1);

  logic [BPW-1:0] bar_px_q;
  logic [2:0]     bar0_q, bar1_q, bar2_q;
  logic           tm1_q, tm2_q;

  assign tm0 = test_mode;

  // Bar index of the stage-0 pixel, plus its trip down to stage 2.
  always_ff @(posedge clkVga or negedge reset) begin
    if (!reset) begin
      bar_px_q <= '0;
      bar0_q   <= 3'd0;
      bar1_q   <= 3'd0;
      bar2_q   <= 3'd0;
      tm1_q    <= 1'b0;
      tm2_q    <= 1'b0;
    end else begin
      if (!act0) begin
        bar_px_q <= '0;
        bar0_q   <= 3'd0;
      end else if (bar_px_q == BPW'(BAR_W - 1)) begin
        bar_px_q <= '0;
        bar0_q   <= bar0_q + 3'd1;
      end else begin
        bar_px_q <= bar_px_q + BPW'(1);
      end
      bar1_q <= bar0_q;
      bar2_q <= bar1_q;
      tm1_q  <= tm0;
      tm2_q  <= tm1_q;
    end
  end
`else
  assign tm0 = 1'b0;
`endif

  // Stage 1: issue the word fetch and launch the control word.
  always_ff @(posedge clkVga or negedge reset) begin
    if (!reset) begin
      p_q        <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      ctl1_q     <= PIX_CTL_IDLE;
    end else begin
      p_q      <= p_d;
      mem_rd_q <= act0 && !tm0;
      // Address only moves on active pixels so it never points past the buffer.
      if (act0) begin
        mem_addr_q <= p_q[PW-1:2];
      end
      ctl1_q <= '{act: act0, hs: hs0, vs: vs0, last: last0, bsel: p_q[1:0]};
    end
  end

  // Stage 2: read data is valid now; align control with it.
  always_ff @(posedge clkVga or negedge reset) begin
    if (!reset) begin
      ctl2_q <= PIX_CTL_IDLE;
    end else begin
      ctl2_q <= ctl1_q;
    end
  end

  assign pix_byte = VGAData[{ctl2_q.bsel, 3'b000} +: 8];

  // Pixel colour for the output register; blanked outside the active area.
  always_comb begin
    rgb_d = 24'd0;
    if (ctl2_q.act) begin
`ifdef VGA_TEST_PATTERN_EN
      rgb_d = tm2_q ? bar_rgb(bar2_q) : {pix_byte, pix_byte, pix_byte};
`else
      rgb_d = {pix_byte, pix_byte, pix_byte};
`endif
    end
  end

  // Stage 3: output registers; frame_done trails the last pixel by one cycle.
  always_ff @(posedge clkVga or negedge reset) begin
    if (!reset) begin
      rgb_q   <= 24'd0;
      vis_q   <= 1'b0;
      hs3_q   <= 1'b1;
      vs3_q   <= 1'b1;
      last3_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      vis_q   <= ctl2_q.act;
      hs3_q   <= ctl2_q.hs;
      vs3_q   <= ctl2_q.vs;
      last3_q <= ctl2_q.last;
      fdone_q <= last3_q;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign H_SyncOut  = hs3_q;
  assign V_SyncOut  = vs3_q;
  assign RedOut     = rgb_q[23:16];
  assign GreenOut   = rgb_q[15:8];
  assign BlueOut    = rgb_q[7:0];
  assign visible    = vis_q;
  assign vga_sync   = 1'b0;
  assign frame_done = fdone_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_scanout
// Brief   : Bench for vga_scanout. A reduced-geometry instance is checked
//           every cycle against a raster-position model; a full 640x480
//           instance checks sync widths, first-fall latency, first pixels
//           and the line-1 fetch address.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3, HT = HA + HFP + HSY + HBP;
  localparam int VA = 4,  VFP = 1, VSY = 2, VBP = 1, VT = VA + VFP + VSY + VBP;
  localparam int AW = 4;
  localparam int BARW = HA / 8;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic act, hs, vs, last, rd;
    logic [AW-1:0] addr;
    logic [7:0] r, g, b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Reduced-geometry DUT
  logic reset = 1'b0, enable = 1'b0, tm = 1'b0;
  logic [AW-1:0] mem_addr;
  logic mem_rd, hso, vso, vis, vsync, fdone, busy;
  logic [31:0] vdata = 32'd0;
  logic [7:0] r, g, b;

  // Full-geometry DUT
  logic rst_f = 1'b0, en_f = 1'b1, tm_f = 1'b0;
  logic [16:0] mem_addr_f;
  logic mem_rd_f, hso_f, vso_f, vis_f, vsync_f, fdone_f, busy_f;
  logic [31:0] vdata_f = 32'd0;
  logic [7:0] r_f, g_f, b_f;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .ADDR_W(AW)
  ) dut (
    .clkVga(clk), .reset(reset), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .mem_addr(mem_addr), .mem_rd(mem_rd), .VGAData(vdata),
    .H_SyncOut(hso), .V_SyncOut(vso), .RedOut(r), .GreenOut(g), .BlueOut(b),
    .visible(vis), .vga_sync(vsync), .frame_done(fdone), .busy(busy)
  );

  vga_scanout dut_full (
    .clkVga(clk), .reset(rst_f), .enable(en_f),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm_f),
`endif
    .mem_addr(mem_addr_f), .mem_rd(mem_rd_f), .VGAData(vdata_f),
    .H_SyncOut(hso_f), .V_SyncOut(vso_f), .RedOut(r_f), .GreenOut(g_f), .BlueOut(b_f),
    .visible(vis_f), .vga_sync(vsync_f), .frame_done(fdone_f), .busy(busy_f)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Framebuffer contents: word n = {n+3, n+2, n+1, n} on its low byte.
  function automatic logic [31:0] word_of(input int n);
    logic [7:0] l;
    l = n[7:0];
    return {l + 8'd3, l + 8'd2, l + 8'd1, l};
  endfunction

  // Gray level of raster pixel (h,v) in a frame ha pixels wide.
  function automatic logic [7:0] pixval(input int h, input int v, input int ha);
    int idx;
    idx = v * ha + h;
    return 8'(((idx / 4) % 256) + (idx % 4));
  endfunction

  // Synchronous read port models
  always @(posedge clk) vdata   <= word_of(int'(mem_addr));
  always @(posedge clk) vdata_f <= word_of(int'(mem_addr_f));

  // What the raster position (h,v) must eventually produce.
  function automatic exp_t tuple_of(input bit run, input int h, input int v, input bit tmv);
    exp_t e;
    int k;
    e.act  = run && (h < HA) && (v < VA);
    e.hs   = !(run && (h >= HA + HFP) && (h < HA + HFP + HSY));
    e.vs   = !(run && (v >= VA + VFP) && (v < VA + VFP + VSY));
    e.last = e.act && (h == HA - 1) && (v == VA - 1);
    e.rd   = e.act && !tmv;
    e.addr = AW'((v * HA + h) / 4);
    e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
    if (e.act) begin
      if (tmv) begin
        k = h / BARW;
        e.r = k[2] ? 8'hFF : 8'h00;
        e.g = k[1] ? 8'hFF : 8'h00;
        e.b = k[0] ? 8'hFF : 8'h00;
      end else begin
        e.r = pixval(h, v, HA);
        e.g = e.r;
        e.b = e.r;
      end
    end
    return e;
  endfunction

  // Model state: running flag and raster position; t0..t3 hold the last
  // four positions' expectations (t0 newest).
  bit run_m = 1'b0;
  int hm = 0, vm = 0;
  exp_t t0, t1, t2, t3;
  bit wrap_m;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_m = 1'b0; hm = 0; vm = 0;
      t0 = tuple_of(1'b0, 0, 0, 1'b0);
      t1 = t0; t2 = t0; t3 = t0;
    end else begin
      t3 = t2; t2 = t1; t1 = t0;
      t0 = tuple_of(run_m, hm, vm, tm);
      if (!run_m) begin
        run_m = enable;
      end else begin
        wrap_m = (hm == HT - 1) && (vm == VT - 1);
        if (hm == HT - 1) begin
          hm = 0;
          vm = (vm == VT - 1) ? 0 : vm + 1;
        end else begin
          hm = hm + 1;
        end
        if (wrap_m) run_m = enable;
      end
      #1;
      if (reset) begin
        chk("H_SyncOut", hso, t2.hs);
        chk("V_SyncOut", vso, t2.vs);
        chk("visible", vis, t2.act);
        chk("RedOut", r, t2.r);
        chk("GreenOut", g, t2.g);
        chk("BlueOut", b, t2.b);
        chk("mem_rd", mem_rd, t0.rd);
        if (t0.rd) chk("mem_addr", mem_addr, t0.addr);
        chk("mem_addr_range", mem_addr <= AW'(15), 1);
        chk("frame_done", fdone, t3.last);
        chk("busy", busy, run_m);
        chk("vga_sync", vsync, 0);
      end
    end
  end

  task automatic wait_pos(input int h, input int v);
    int k = 0;
    while (!(run_m && hm == h && vm == v) && k < 3 * FRAME) begin
      @(negedge clk);
      k++;
    end
    chk("wait_pos_timeout", (run_m && hm == h && vm == v), 1);
  endtask

  // From IDLE with enable high: three blank samples, then pixel (0,0), (1,0).
  task automatic check_restart();
    repeat (3) begin
      @(posedge clk); #1;
      chk("restart_vis_low", vis, 0);
    end
    @(posedge clk); #1;
    chk("restart_vis_high", vis, 1);
    chk("restart_px0", r, 8'h00);
    @(posedge clk); #1;
    chk("restart_px1", r, 8'h01);
    @(negedge clk);
  endtask

  bit full_done = 1'b0;

  // Full-geometry checks
  initial begin : full_chk
    int e, t_leave, n_vis, n_rd;
    int falls[$], rises[$];
    logic prev_h;
    logic [7:0] exp8 [8];
    exp8 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
    e = 0; t_leave = -1; n_vis = 0; n_rd = 0; prev_h = 1'b1;
    @(posedge rst_f);
    while (e < 3000) begin
      @(posedge clk); #1;
      e++;
      if (t_leave < 0 && busy_f) t_leave = e;
      if (prev_h && !hso_f) falls.push_back(e);
      if (!prev_h && hso_f) rises.push_back(e);
      prev_h = hso_f;
      if (vis_f && n_vis < 8) begin
        chk($sformatf("full_px%0d_r", n_vis), r_f, exp8[n_vis]);
        chk($sformatf("full_px%0d_g", n_vis), g_f, exp8[n_vis]);
        chk($sformatf("full_px%0d_b", n_vis), b_f, exp8[n_vis]);
        n_vis++;
      end
      if (mem_rd_f) begin
        if (n_rd == 640) chk("full_addr_line1", mem_addr_f, 160);
        n_rd++;
      end
    end
    chk("full_leave_idle_edge", t_leave, 1);
    chk("full_hsync_falls", falls.size() >= 3, 1);
    chk("full_hsync_rises", rises.size() >= 2, 1);
    if (falls.size() >= 2 && rises.size() >= 2) begin
      chk("full_first_fall_latency", falls[0] - t_leave, 659);
      chk("full_hsync_period", falls[1] - falls[0], 800);
      chk("full_hsync_width0", rises[0] - falls[0], 96);
      chk("full_hsync_width1", rises[1] - falls[1], 96);
    end
    chk("full_vsync_high", vso_f, 1);
`ifdef VGA_TEST_PATTERN_EN
    begin : pattern
      int x, k;
      bit started, seen85, seen639;
      logic prev_v;
      tm_f = 1'b1;
      repeat (900) @(posedge clk);
      x = 0; k = 0; started = 0; seen85 = 0; seen639 = 0; prev_v = 1'b1;
      while (k < 1700 && !seen639) begin
        @(posedge clk); #1;
        k++;
        chk("pattern_mem_rd", mem_rd_f, 0);
        if (vis_f && !prev_v) begin started = 1; x = 0; end
        if (vis_f && started) begin
          if (x == 85) begin
            chk("pattern_x85", {r_f, g_f, b_f}, 24'h0000FF);
            seen85 = 1;
          end
          if (x == 639) begin
            chk("pattern_x639", {r_f, g_f, b_f}, 24'hFFFFFF);
            seen639 = 1;
          end
          x++;
        end
        prev_v = vis_f;
      end
      chk("pattern_seen", {seen85, seen639}, 2'b11);
      tm_f = 1'b0;
    end
`endif
    full_done = 1'b1;
  end

  // Main stimulus
  initial begin : main
    int k;
    chk("model_pin_px5", pixval(5, 0, HA), 8'h02);
    chk("model_pin_line1", pixval(0, 1, HA), 8'h04);
    chk("model_pin_full", pixval(7, 0, 640), 8'h04);

    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hs", hso, 1); chk("reset_vs", vso, 1);
    chk("reset_busy", busy, 0); chk("reset_rgb", {r, g, b}, 0);
    @(negedge clk);
    reset = 1'b1;
    rst_f = 1'b1;
    check_restart();
    repeat (3 * FRAME) @(negedge clk);

    // Random enable (and pattern) toggling
    repeat (30) begin
      enable = ($urandom_range(0, 3) != 0);
`ifdef VGA_TEST_PATTERN_EN
      tm = ($urandom_range(0, 2) == 0);
`endif
      repeat ($urandom_range(1, 400)) @(negedge clk);
    end
    tm = 1'b0;

    // Stop mid-frame: the frame finishes, then the outputs sit idle.
    enable = 1'b1;
    wait_pos(8, 2);
    enable = 1'b0;
    k = 0;
    while (run_m && k < 2 * FRAME) begin @(negedge clk); k++; end
    chk("stop_reached_idle", run_m, 0);
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_hs", hso, 1);
    chk("idle_vs", vso, 1);
    chk("idle_rgb", {r, g, b}, 0);
    chk("idle_vis", vis, 0);
    enable = 1'b1;
    check_restart();

    // Asynchronous reset mid-line
    wait_pos(10, 2);
    #2 reset = 1'b0;
    #1;
    chk("areset_hs", hso, 1); chk("areset_vs", vso, 1);
    chk("areset_rgb", {r, g, b}, 0); chk("areset_vis", vis, 0);
    chk("areset_addr", mem_addr, 0); chk("areset_rd", mem_rd, 0);
    chk("areset_fdone", fdone, 0); chk("areset_busy", busy, 0);
    chk("areset_vsync", vsync, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_restart();
    repeat (2 * FRAME) @(negedge clk);

    enable = 1'b0;
    k = 0;
    while (run_m && k < 2 * FRAME) begin @(negedge clk); k++; end
    chk("final_idle", run_m, 0);
    repeat (10) @(negedge clk);

    k = 0;
    while (!full_done && k < 20000) begin @(negedge clk); k++; end
    chk("full_checks_done", full_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
